rgb_pwm_driver: RTL and testbench

- Downstream stage of the colour-wheel generator: accepts 8-bit red/green/blue duty values over a valid/ready handshake and drives three LED pins with 256-step PWM.
- Double-buffered: accepted duties go to a pending register and are applied only at a PWM period boundary, giving glitch-free updates.
- Emits a one-cycle period_start pulse so the upstream generator can pace wheel stepping to whole PWM periods.

---
 rtl/rgb_pwm_driver.sv | 128 ++++++++++++
 tb/tb_rgb_pwm_driver.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_pwm_driver.sv
// Three-channel 256-step PWM LED driver with a double-buffered duty handshake.
// Optional gamma mapping of the incoming duties is enabled by defining RGB_PWM_GAMMA_EN.
module rgb_pwm_driver #(
    parameter int DIV     = 1,
    parameter bit OUT_INV = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] duty_r,
    input  logic [7:0] duty_g,
    input  logic [7:0] duty_b,
    input  logic       duty_valid,
    output logic       duty_ready,
    output logic       period_start,
    output logic       red,
    output logic       green,
    output logic       blue
);

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);

    // Perceptual correction applied on the way into the pending buffer.
    function automatic logic [7:0] duty_map(input logic [7:0] d);
        logic [15:0] prod;
`ifdef RGB_PWM_GAMMA_EN
        prod = (16'(d) * 16'(d)) + 16'd255;
`else
        prod = {d, 8'd0};
`endif
        return prod[15:8];
    endfunction

    logic [DW-1:0] div_cnt_q, div_cnt_d;
    logic [7:0]    pwm_cnt_q, pwm_cnt_d;
    logic [7:0]    act_r_q, act_r_d, act_g_q, act_g_d, act_b_q, act_b_d;
    logic [7:0]    pend_r_q, pend_r_d, pend_g_q, pend_g_d, pend_b_q, pend_b_d;
    logic          pend_full_q, pend_full_d;
    logic          period_start_q, period_start_d;
    logic          red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic          tick_s, boundary_s, capture_s;

    // Next-state logic: prescaler, PWM counter, handshake capture and boundary transfer.
    always_comb begin
        tick_s     = (div_cnt_q == DIV_LAST);
        boundary_s = tick_s && (pwm_cnt_q == 8'd255);
        capture_s  = duty_valid && !pend_full_q;

        div_cnt_d      = div_cnt_q;
        pwm_cnt_d      = pwm_cnt_q;
        act_r_d        = act_r_q;
        act_g_d        = act_g_q;
        act_b_d        = act_b_q;
        pend_r_d       = pend_r_q;
        pend_g_d       = pend_g_q;
        pend_b_d       = pend_b_q;
        pend_full_d    = pend_full_q;

        if (tick_s) begin
            div_cnt_d = '0;
            pwm_cnt_d = pwm_cnt_q + 8'd1;
        end else begin
            div_cnt_d = div_cnt_q + DW'(1);
            pwm_cnt_d = pwm_cnt_q;
        end

        period_start_d = boundary_s;

        // Transfer and capture are exclusive: one needs a full buffer, the other an empty one.
        if (boundary_s && pend_full_q) begin
            act_r_d     = pend_r_q;
            act_g_d     = pend_g_q;
            act_b_d     = pend_b_q;
            pend_full_d = 1'b0;
        end else if (capture_s) begin
            pend_r_d    = duty_map(duty_r);
            pend_g_d    = duty_map(duty_g);
            pend_b_d    = duty_map(duty_b);
            pend_full_d = 1'b1;
        end else begin
            pend_full_d = pend_full_q;
        end

        red_d   = (pwm_cnt_q < act_r_q) ^ OUT_INV;
        green_d = (pwm_cnt_q < act_g_q) ^ OUT_INV;
        blue_d  = (pwm_cnt_q < act_b_q) ^ OUT_INV;
    end

    // State registers; pins reset to the inactive level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt_q      <= '0;
            pwm_cnt_q      <= 8'd0;
            act_r_q        <= 8'd0;
            act_g_q        <= 8'd0;
            act_b_q        <= 8'd0;
            pend_r_q       <= 8'd0;
            pend_g_q       <= 8'd0;
            pend_b_q       <= 8'd0;
            pend_full_q    <= 1'b0;
            period_start_q <= 1'b0;
            red_q          <= OUT_INV;
            green_q        <= OUT_INV;
            blue_q         <= OUT_INV;
        end else begin
            div_cnt_q      <= div_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            act_r_q        <= act_r_d;
            act_g_q        <= act_g_d;
            act_b_q        <= act_b_d;
            pend_r_q       <= pend_r_d;
            pend_g_q       <= pend_g_d;
            pend_b_q       <= pend_b_d;
            pend_full_q    <= pend_full_d;
            period_start_q <= period_start_d;
            red_q          <= red_d;
            green_q        <= green_d;
            blue_q         <= blue_d;
        end
    end

    assign duty_ready   = ~pend_full_q;
    assign period_start = period_start_q;
    assign red          = red_q;
    assign green        = green_q;
    assign blue         = blue_q;

endmodule

// File: tb/tb_rgb_pwm_driver.sv
// Directed bench for rgb_pwm_driver: one DIV=1 active-high instance and one DIV=4 active-low instance.
module tb_rgb_pwm_driver;

`ifdef RGB_PWM_GAMMA_EN
    localparam int E_BAS_R = 16,  E_BAS_G = 0,   E_BAS_B = 255;
    localparam int E_A_R   = 1,   E_A_G   = 2,   E_A_B   = 4;
    localparam int E_B_R   = 157, E_B_G   = 40,  E_B_B   = 10;
    localparam int E_C_R   = 40,  E_C_G   = 88,  E_C_B   = 1;
    localparam int E_GM_R  = 64,  E_GM_G  = 255, E_GM_B  = 1;
    localparam int E_PRE   = 0;
    localparam int E_DIV_RH = 768;
`else
    localparam int E_BAS_R = 64,  E_BAS_G = 0,   E_BAS_B = 255;
    localparam int E_A_R   = 10,  E_A_G   = 20,  E_A_B   = 30;
    localparam int E_B_R   = 200, E_B_G   = 100, E_B_B   = 50;
    localparam int E_C_R   = 100, E_C_G   = 150, E_C_B   = 7;
    localparam int E_GM_R  = 128, E_GM_G  = 255, E_GM_B  = 16;
    localparam int E_PRE   = 43;
    localparam int E_DIV_RH = 512;
`endif

    logic       clk = 1'b0;
    logic       rst0, rst1, v0, v1;
    logic [7:0] r0, g0, b0, r1, g1, b1;
    logic       rdy0, ps0, red0, grn0, blu0;
    logic       rdy1, ps1, red1, grn1, blu1;
    int         total = 0;
    int         bad = 0;

    always #5 clk = ~clk;

    rgb_pwm_driver #(.DIV(1), .OUT_INV(1'b0)) dut0 (
        .clk(clk), .rst(rst0), .duty_r(r0), .duty_g(g0), .duty_b(b0), .duty_valid(v0),
        .duty_ready(rdy0), .period_start(ps0), .red(red0), .green(grn0), .blue(blu0)
    );

    rgb_pwm_driver #(.DIV(4), .OUT_INV(1'b1)) dut1 (
        .clk(clk), .rst(rst1), .duty_r(r1), .duty_g(g1), .duty_b(b1), .duty_valid(v1),
        .duty_ready(rdy1), .period_start(ps1), .red(red1), .green(grn1), .blue(blu1)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int sel, output logic ps, output logic rd,
                          output logic r, output logic g, output logic b);
        if (sel == 0) begin
            ps = ps0; rd = rdy0; r = red0; g = grn0; b = blu0;
        end else begin
            ps = ps1; rd = rdy1; r = red1; g = grn1; b = blu1;
        end
    endtask

    // Step until period_start is seen; counts cover the samples before the pulse.
    task automatic wait_ps(input int sel, input int limit, output int n,
                           output int rh, output int gh, output int bh, output int rdy);
        logic ps, rd, r, g, b;
        n = 0; rh = 0; gh = 0; bh = 0; rdy = 0;
        for (int i = 1; i <= limit; i++) begin
            step();
            sample(sel, ps, rd, r, g, b);
            if (ps) begin
                n = i;
                break;
            end
            rh += int'(r); gh += int'(g); bh += int'(b); rdy += int'(rd);
        end
    endtask

    task automatic measure(input int sel, input int len, output int rh, output int gh,
                           output int bh, output int rdy, output int psn, output logic ps_last);
        logic ps, rd, r, g, b;
        rh = 0; gh = 0; bh = 0; rdy = 0; psn = 0; ps_last = 1'b0;
        for (int i = 0; i < len; i++) begin
            step();
            sample(sel, ps, rd, r, g, b);
            rh += int'(r); gh += int'(g); bh += int'(b); rdy += int'(rd); psn += int'(ps);
            ps_last = ps;
        end
    endtask

    task automatic test_reset();
        int n, rh, gh, bh, rdy;
        rst0 = 1'b1; rst1 = 1'b1; v0 = 1'b0; v1 = 1'b0;
        r0 = 8'd0; g0 = 8'd0; b0 = 8'd0; r1 = 8'd0; g1 = 8'd0; b1 = 8'd0;
        repeat (3) step();
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL rst_ready0: got %b want 1", rdy0); end
        total++; if (ps0 !== 1'b0) begin bad++; $display("FAIL rst_ps0: got %b want 0", ps0); end
        total++; if ({red0, grn0, blu0} !== 3'b000) begin bad++; $display("FAIL rst_pins0: got %b want 000", {red0, grn0, blu0}); end
        total++; if ({red1, grn1, blu1} !== 3'b111) begin bad++; $display("FAIL rst_pins1: got %b want 111", {red1, grn1, blu1}); end
        total++; if (rdy1 !== 1'b1) begin bad++; $display("FAIL rst_ready1: got %b want 1", rdy1); end
        rst0 = 1'b0; rst1 = 1'b0;
        wait_ps(0, 400, n, rh, gh, bh, rdy);
        total++; if (n !== 256) begin bad++; $display("FAIL rst_first_ps: got %0d want 256", n); end
        total++; if (rh + gh + bh !== 0) begin bad++; $display("FAIL rst_idle_pins: got %0d want 0", rh + gh + bh); end
        total++; if (rdy !== 255) begin bad++; $display("FAIL rst_idle_ready: got %0d want 255", rdy); end
        wait_ps(0, 400, n, rh, gh, bh, rdy);
        total++; if (n !== 256) begin bad++; $display("FAIL rst_ps_period: got %0d want 256", n); end
    endtask

    task automatic test_basic();
        int n, rh, gh, bh, rdy, psn;
        logic pl;
        repeat (10) step();
        r0 = 8'd64; g0 = 8'd0; b0 = 8'd255; v0 = 1'b1;
        step();
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL basic_ready_drop: got %b want 0", rdy0); end
        v0 = 1'b0;
        wait_ps(0, 300, n, rh, gh, bh, rdy);
        total++; if (n !== 245) begin bad++; $display("FAIL basic_wait: got %0d want 245", n); end
        total++; if (rh + gh + bh !== 0) begin bad++; $display("FAIL basic_pins_before: got %0d want 0", rh + gh + bh); end
        total++; if (rdy !== 0) begin bad++; $display("FAIL basic_ready_low: got %0d want 0", rdy); end
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL basic_ready_back: got %b want 1", rdy0); end
        measure(0, 256, rh, gh, bh, rdy, psn, pl);
        total++; if (rh !== E_BAS_R) begin bad++; $display("FAIL basic_red: got %0d want %0d", rh, E_BAS_R); end
        total++; if (gh !== E_BAS_G) begin bad++; $display("FAIL basic_green: got %0d want %0d", gh, E_BAS_G); end
        total++; if (bh !== E_BAS_B) begin bad++; $display("FAIL basic_blue: got %0d want %0d", bh, E_BAS_B); end
        total++; if (psn !== 1 || pl !== 1'b1) begin bad++; $display("FAIL basic_ps: got %0d/%b want 1/1", psn, pl); end
    endtask

    task automatic test_back_to_back();
        int n, rh, gh, bh, rdy, psn;
        logic pl;
        repeat (20) step();
        r0 = 8'd10; g0 = 8'd20; b0 = 8'd30; v0 = 1'b1;
        step();
        total++; if (rdy0 !== 1'b0) begin bad++; $display("FAIL b2b_a_accept: got %b want 0", rdy0); end
        r0 = 8'd200; g0 = 8'd100; b0 = 8'd50;
        wait_ps(0, 300, n, rh, gh, bh, rdy);
        total++; if (n !== 235) begin bad++; $display("FAIL b2b_wait: got %0d want 235", n); end
        total++; if (rdy !== 0) begin bad++; $display("FAIL b2b_b_blocked: got %0d want 0", rdy); end
        total++; if (rh !== E_PRE) begin bad++; $display("FAIL b2b_old_red: got %0d want %0d", rh, E_PRE); end
        total++; if (rdy0 !== 1'b1) begin bad++; $display("FAIL b2b_ready_at_bnd: got %b want 1", rdy0); end
        measure(0, 256, rh, gh, bh, rdy, psn, pl);
        v0 = 1'b0;
        total++; if ({rh, gh, bh} !== {E_A_R, E_A_G, E_A_B}) begin bad++; $display("FAIL b2b_a_duty: got %0d,%0d,%0d want %0d,%0d,%0d", rh, gh, bh, E_A_R, E_A_G, E_A_B); end
        total++; if (rdy !== 1) begin bad++; $display("FAIL b2b_b_pending: got %0d want 1", rdy); end
        measure(0, 256, rh, gh, bh, rdy, psn, pl);
        total++; if ({rh, gh, bh} !== {E_B_R, E_B_G, E_B_B}) begin bad++; $display("FAIL b2b_b_duty: got %0d,%0d,%0d want %0d,%0d,%0d", rh, gh, bh, E_B_R, E_B_G, E_B_B); end
        total++; if (rdy !== 256 || pl !== 1'b1) begin bad++; $display("FAIL b2b_b_idle: got %0d/%b want 256/1", rdy, pl); end
    endtask

    task automatic test_boundary_accept();
        int rh, gh, bh, rdy, psn;
        logic pl;
        repeat (255) step();
        r0 = 8'd100; g0 = 8'd150; b0 = 8'd7; v0 = 1'b1;
        step();
        v0 = 1'b0;
        total++; if (ps0 !== 1'b1 || rdy0 !== 1'b0) begin bad++; $display("FAIL bnd_edge: got ps=%b rdy=%b want ps=1 rdy=0", ps0, rdy0); end
        measure(0, 256, rh, gh, bh, rdy, psn, pl);
        total++; if ({rh, gh, bh} !== {E_B_R, E_B_G, E_B_B}) begin bad++; $display("FAIL bnd_not_applied: got %0d,%0d,%0d want %0d,%0d,%0d", rh, gh, bh, E_B_R, E_B_G, E_B_B); end
        total++; if (rdy !== 1) begin bad++; $display("FAIL bnd_pending: got %0d want 1", rdy); end
        measure(0, 256, rh, gh, bh, rdy, psn, pl);
        total++; if ({rh, gh, bh} !== {E_C_R, E_C_G, E_C_B}) begin bad++; $display("FAIL bnd_applied: got %0d,%0d,%0d want %0d,%0d,%0d", rh, gh, bh, E_C_R, E_C_G, E_C_B); end
    endtask

    task automatic test_gamma_vectors();
        int n, rh, gh, bh, rdy, psn;
        logic pl;
        repeat (5) step();
        r0 = 8'd128; g0 = 8'd255; b0 = 8'd16; v0 = 1'b1;
        step();
        v0 = 1'b0;
        wait_ps(0, 300, n, rh, gh, bh, rdy);
        total++; if (n !== 250) begin bad++; $display("FAIL gm_wait: got %0d want 250", n); end
        measure(0, 256, rh, gh, bh, rdy, psn, pl);
        total++; if ({rh, gh, bh} !== {E_GM_R, E_GM_G, E_GM_B}) begin bad++; $display("FAIL gm_duty: got %0d,%0d,%0d want %0d,%0d,%0d", rh, gh, bh, E_GM_R, E_GM_G, E_GM_B); end
    endtask

    task automatic test_div_inv_reset();
        int n, rh, gh, bh, rdy, psn;
        logic pl;
        r1 = 8'd128; g1 = 8'd0; b1 = 8'd0; v1 = 1'b1;
        step();
        v1 = 1'b0;
        total++; if (rdy1 !== 1'b0) begin bad++; $display("FAIL div_accept: got %b want 0", rdy1); end
        wait_ps(1, 2100, n, rh, gh, bh, rdy);
        total++; if (n === 0) begin bad++; $display("FAIL div_wait: got timeout want period_start"); end
        measure(1, 1024, rh, gh, bh, rdy, psn, pl);
        total++; if (rh !== E_DIV_RH) begin bad++; $display("FAIL div_red_high: got %0d want %0d", rh, E_DIV_RH); end
        total++; if (gh !== 1024 || bh !== 1024) begin bad++; $display("FAIL div_gb_inactive: got %0d,%0d want 1024,1024", gh, bh); end
        total++; if (psn !== 1 || pl !== 1'b1) begin bad++; $display("FAIL div_period: got %0d/%b want 1/1", psn, pl); end
        r1 = 8'd50; g1 = 8'd60; b1 = 8'd70; v1 = 1'b1;
        step();
        v1 = 1'b0;
        repeat (100) step();
        total++; if (red1 !== 1'b0) begin bad++; $display("FAIL mid_red_active: got %b want 0", red1); end
        #3;
        rst1 = 1'b1;
        #1;
        total++; if ({red1, grn1, blu1} !== 3'b111) begin bad++; $display("FAIL mid_rst_pins: got %b want 111", {red1, grn1, blu1}); end
        total++; if (rdy1 !== 1'b1 || ps1 !== 1'b0) begin bad++; $display("FAIL mid_rst_ctl: got rdy=%b ps=%b want 1/0", rdy1, ps1); end
        repeat (2) step();
        rst1 = 1'b0;
        wait_ps(1, 1100, n, rh, gh, bh, rdy);
        total++; if (n !== 1024) begin bad++; $display("FAIL mid_first_ps: got %0d want 1024", n); end
        total++; if (rh !== 1023) begin bad++; $display("FAIL mid_red_idle: got %0d want 1023", rh); end
        measure(1, 1024, rh, gh, bh, rdy, psn, pl);
        total++; if (rh !== 1024 || rdy !== 1024) begin bad++; $display("FAIL mid_pending_lost: got red=%0d rdy=%0d want 1024/1024", rh, rdy); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_boundary_accept();
        test_gamma_vectors();
        test_div_inv_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
